// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB PWM controller: operating modes.
package rgb_pkg;

    // Operating modes, sampled by the controller at each PWM period boundary.
    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_FADE   = 2'b10,
        MODE_OFF    = 2'b11
    } mode_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow target register, boundary-updated active duty
// (direct copy or single-step fade) and the counter comparator.
module pwm_channel
    import rgb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] cnt_i,
    input  logic         boundary_i,
    input  logic         load_i,
    input  logic [W-1:0] duty_i,
    input  mode_t        mode_i,
    output logic         raw_o,
    output logic         busy_o
);

    logic [W-1:0] target_q, target_d;
    logic [W-1:0] active_q, active_d;

    // Shadow register: last load wins until the next boundary consumes it.
    always_comb begin
        target_d = target_q;
        if (load_i) begin
            target_d = duty_i;
        end
    end

    // Active duty only changes at the period boundary, using the target held
    // before this edge, so a load on the boundary clock waits one more period.
    always_comb begin
        active_d = active_q;
        if (boundary_i) begin
            if (mode_i == MODE_FADE) begin
                if (active_q < target_q) begin
                    active_d = active_q + 1'b1;
                end else if (active_q > target_q) begin
                    active_d = active_q - 1'b1;
                end
            end else begin
                active_d = target_q;
            end
        end
    end

    // Target and active duty registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            active_q <= '0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
        end
    end

    assign raw_o  = (cnt_i < active_q);
    assign busy_o = (active_q != target_q);

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel PWM controller for RGB LEDs: prescaler, shared period counter,
// per-channel duty logic, blink/off gating and registered outputs.
module rgb_pwm_ctrl
    import rgb_pkg::*;
#(
    parameter int CH       = 3,
    parameter int W        = 8,
    parameter int PRESCALE = 4,
    parameter int BLINK_P  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*W-1:0] duty_in,
    input  logic            load,
    input  logic [1:0]      mode,
    output logic [CH-1:0]   pwm_out,
    output logic            period_tick,
    output logic            busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLINK_P > 0) ? BLINK_P : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'((1 << BLINK_P) - 1);

    logic [PW-1:0] psc_q, psc_d;
    logic [W-1:0]  cnt_q, cnt_d;
    mode_t         mode_q, mode_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          phase_q, phase_d;
    logic [CH-1:0] pwm_q, pwm_d;
    logic          tick_q, tick_d;

    mode_t         mode_in;
    logic          tick;
    logic          boundary;
    logic          gate;
    logic [CH-1:0] raw;
    logic [CH-1:0] busy_vec;

    assign mode_in  = mode_t'(mode);
    assign tick     = (psc_q == PSC_LAST);
    assign boundary = tick && (cnt_q == '1);

    // Channels see the incoming mode; they only act on it at the boundary,
    // which is exactly when that mode is latched for the new period.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_channel #(
            .W(W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .cnt_i     (cnt_q),
            .boundary_i(boundary),
            .load_i    (load),
            .duty_i    (duty_in[i*W +: W]),
            .mode_i    (mode_in),
            .raw_o     (raw[i]),
            .busy_o    (busy_vec[i])
        );
    end

    // Prescaler, period counter, mode latch and blink phase next state.
    always_comb begin
        psc_d   = tick ? '0 : psc_q + 1'b1;
        cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
        mode_d  = boundary ? mode_in : mode_q;
        blk_d   = blk_q;
        phase_d = phase_q;
        if (boundary && (mode_in == MODE_BLINK)) begin
            if (mode_q != MODE_BLINK) begin
                blk_d   = '0;
                phase_d = 1'b1;
            end else if (blk_q == BLK_LAST) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d = blk_q + 1'b1;
            end
        end
    end

    // Output gating: off forces low, blink masks with the phase bit.
    always_comb begin
        gate   = (mode_q != MODE_OFF) && ((mode_q != MODE_BLINK) || phase_q);
        pwm_d  = raw & {CH{gate}};
        tick_d = boundary;
    end

    // Timebase, mode and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_STATIC;
            blk_q   <= '0;
            phase_q <= 1'b1;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            psc_q   <= psc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign busy        = |busy_vec;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Self-checking bench for rgb_pwm_ctrl (CH=3, W=4, PRESCALE=2, BLINK_P=1).
module tb_rgb_pwm_ctrl;

    localparam int CH       = 3;
    localparam int W        = 4;
    localparam int PRESCALE = 2;
    localparam int BLINK_P  = 1;
    localparam int PER      = 1 << W;
    localparam int PCLK     = PER * PRESCALE;
    localparam int DW       = CH * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] duty_in = '0;
    logic          load = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CH-1:0] pwm_out;
    logic          period_tick;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_pwm_ctrl #(
        .CH      (CH),
        .W       (W),
        .PRESCALE(PRESCALE),
        .BLINK_P (BLINK_P)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .duty_in    (duty_in),
        .load       (load),
        .mode       (mode),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .busy       (busy)
    );

    // Reference model: time position derived from clocks since reset release.
    int unsigned   m_k;
    int unsigned   m_bp;
    int            m_tgt[CH];
    int            m_act[CH];
    int            m_mode;
    logic [CH-1:0] m_pwm;
    logic          m_tick;
    logic          m_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_bp = 0; m_mode = 0;
            for (int i = 0; i < CH; i++) begin m_tgt[i] = 0; m_act[i] = 0; end
            m_pwm = '0; m_tick = 1'b0; m_busy = 1'b0;
        end else begin : mstep
            int unsigned c;
            bit bnd;
            bit show;
            c    = (m_k / PRESCALE) % PER;
            bnd  = ((m_k + 1) % PCLK) == 0;
            show = (m_mode != 3) && !((m_mode == 1) && (((m_bp >> BLINK_P) & 1) == 1));
            for (int i = 0; i < CH; i++) m_pwm[i] = show && (c < m_act[i]);
            m_tick = bnd;
            if (bnd) begin
                for (int i = 0; i < CH; i++) begin
                    if (mode == 2'b10) m_act[i] += (m_tgt[i] > m_act[i]) ? 1 : (m_tgt[i] < m_act[i]) ? -1 : 0;
                    else m_act[i] = m_tgt[i];
                end
                if (mode == 2'b01) m_bp = (m_mode == 1) ? m_bp + 1 : 0;
                m_mode = int'(mode);
            end
            if (load) for (int i = 0; i < CH; i++) m_tgt[i] = int'(duty_in[i*W +: W]);
            m_k++;
            m_busy = 1'b0;
            for (int i = 0; i < CH; i++) if (m_act[i] != m_tgt[i]) m_busy = 1'b1;
        end
    end

    // Observations gathered over one PWM period.
    int   ms_hi[CH];
    int   ms_rise[CH];
    int   ms_ticks;
    int   ms_mism;
    logic ms_tick_last;
    logic ms_busy_last;

    task automatic pulse_load(input logic [DW-1:0] d);
        duty_in = d;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2 * PCLK; n++) begin
            @(negedge clk);
            if (period_tick) begin ok = 1'b1; break; end
        end
    endtask

    task automatic measure_period(input int load_at, input logic [DW-1:0] nd);
        logic [CH-1:0] prev;
        prev = pwm_out;
        ms_ticks = 0;
        ms_mism  = 0;
        for (int i = 0; i < CH; i++) begin ms_hi[i] = 0; ms_rise[i] = 0; end
        for (int s = 1; s <= PCLK; s++) begin
            @(negedge clk);
            if ({pwm_out, period_tick, busy} !== {m_pwm, m_tick, m_busy}) ms_mism++;
            for (int i = 0; i < CH; i++) begin
                if (pwm_out[i]) ms_hi[i]++;
                if (pwm_out[i] && !prev[i]) ms_rise[i]++;
            end
            if (period_tick) ms_ticks++;
            prev = pwm_out;
            load = 1'b0;
            if (s == load_at) begin duty_in = nd; load = 1'b1; end
        end
        load = 1'b0;
        ms_tick_last = period_tick;
        ms_busy_last = busy;
    endtask

    task automatic test_reset;
        int first;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({pwm_out, period_tick, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got pwm=%b tick=%b busy=%b, want all 0", pwm_out, period_tick, busy);
        end
        rst_n = 1'b1;
        first = 0;
        for (int n = 1; n <= 3 * PCLK; n++) begin
            @(negedge clk);
            if (period_tick) begin first = n; break; end
        end
        checks++;
        if (first != PCLK) begin
            errors++; $display("FAIL reset_first_tick: got clk %0d, want %0d", first, PCLK);
        end
    endtask

    task automatic test_static;
        bit ok;
        mode = 2'b00;
        pulse_load({4'd15, 4'd0, 4'd4});
        wait_tick(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL static_wait: no period_tick within %0d clk", 2 * PCLK); end
        measure_period(-1, '0);
        checks++;
        if (ms_hi[0] != 8) begin errors++; $display("FAIL static_R: got %0d high clk, want 8", ms_hi[0]); end
        checks++;
        if (ms_hi[1] != 0) begin errors++; $display("FAIL static_G: got %0d high clk, want 0", ms_hi[1]); end
        checks++;
        if (ms_hi[2] != 30) begin errors++; $display("FAIL static_B: got %0d high clk, want 30", ms_hi[2]); end
        checks++;
        if (ms_ticks != 1 || ms_tick_last !== 1'b1) begin
            errors++; $display("FAIL static_tick: got %0d ticks last=%b, want 1 last=1", ms_ticks, ms_tick_last);
        end
        checks++;
        if (ms_mism != 0) begin errors++; $display("FAIL static_model: got %0d model disagreements, want 0", ms_mism); end
    endtask

    task automatic test_shadow;
        measure_period(10, {4'd15, 4'd0, 4'd8});
        checks++;
        if (ms_hi[0] != 8 || ms_rise[0] != 1) begin
            errors++; $display("FAIL shadow_cur: got high=%0d rises=%0d, want 8/1", ms_hi[0], ms_rise[0]);
        end
        measure_period(-1, '0);
        checks++;
        if (ms_hi[0] != 16 || ms_rise[0] != 1) begin
            errors++; $display("FAIL shadow_next: got high=%0d rises=%0d, want 16/1", ms_hi[0], ms_rise[0]);
        end
    endtask

    task automatic test_load_on_boundary;
        int exp_hi[3] = '{16, 16, 24};
        for (int p = 0; p < 3; p++) begin
            measure_period((p == 0) ? PCLK - 1 : -1, {4'd15, 4'd0, 4'd12});
            checks++;
            if (ms_hi[0] != exp_hi[p]) begin
                errors++; $display("FAIL boundary_load_p%0d: got %0d high clk, want %0d", p, ms_hi[0], exp_hi[p]);
            end
        end
    endtask

    task automatic test_fade;
        bit   ok;
        int   exp_hi[3] = '{2, 4, 6};
        logic exp_busy[3] = '{1'b1, 1'b0, 1'b0};
        mode = 2'b00;
        pulse_load('0);
        wait_tick(ok);
        mode = 2'b10;
        pulse_load({4'd0, 4'd0, 4'd3});
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL fade_busy_load: got %b, want 1", busy); end
        wait_tick(ok);
        checks++;
        if (!ok || busy !== 1'b1) begin errors++; $display("FAIL fade_start: got tick_ok=%b busy=%b, want 1/1", ok, busy); end
        for (int p = 0; p < 3; p++) begin
            measure_period(-1, '0);
            checks++;
            if (ms_hi[0] != exp_hi[p] || ms_busy_last !== exp_busy[p]) begin
                errors++; $display("FAIL fade_p%0d: got high=%0d busy=%b, want %0d/%b", p, ms_hi[0], ms_busy_last, exp_hi[p], exp_busy[p]);
            end
        end
    endtask

    task automatic test_blink;
        bit ok;
        int exp_hi[6] = '{30, 30, 0, 0, 30, 30};
        mode = 2'b01;
        pulse_load({4'd0, 4'd0, 4'd15});
        wait_tick(ok);
        for (int p = 0; p < 6; p++) begin
            measure_period(-1, '0);
            checks++;
            if (ms_hi[0] != exp_hi[p] || ms_ticks != 1 || ms_tick_last !== 1'b1 || ms_mism != 0) begin
                errors++; $display("FAIL blink_p%0d: got high=%0d ticks=%0d mism=%0d, want %0d/1/0", p, ms_hi[0], ms_ticks, ms_mism, exp_hi[p]);
            end
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        mode = 2'b00;
        pulse_load({4'd0, 4'd0, 4'd8});
        wait_tick(ok);
        mode = 2'b10;
        pulse_load({4'd0, 4'd0, 4'd15});
        wait_tick(ok);
        repeat (2) @(negedge clk);
        checks++;
        if (pwm_out[0] !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got pwm0=%b busy=%b, want 1/1", pwm_out[0], busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 3'b000 || busy !== 1'b0 || period_tick !== 1'b0) begin
            errors++; $display("FAIL areset_now: got pwm=%b busy=%b tick=%b, want 000/0/0", pwm_out, busy, period_tick);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        measure_period(-1, '0);
        checks++;
        if (ms_hi[0] + ms_hi[1] + ms_hi[2] != 0 || ms_tick_last !== 1'b1 || ms_mism != 0) begin
            errors++; $display("FAIL areset_restart: got high=%0d tick_last=%b mism=%0d, want 0/1/0",
                               ms_hi[0] + ms_hi[1] + ms_hi[2], ms_tick_last, ms_mism);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            checks++;
            if ({pwm_out, period_tick, busy} !== {m_pwm, m_tick, m_busy}) begin
                errors++;
                $display("FAIL random_cycle%0d: got pwm=%b tick=%b busy=%b, want pwm=%b tick=%b busy=%b",
                         n, pwm_out, period_tick, busy, m_pwm, m_tick, m_busy);
            end
            load = 1'b0;
            if ($urandom_range(0, 11) == 0) begin duty_in = DW'($urandom); load = 1'b1; end
            if ($urandom_range(0, 149) == 0) mode = 2'($urandom);
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset;
        test_static;
        test_shadow;
        test_load_on_boundary;
        test_fade;
        test_blink;
        test_async_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
